// File: rtl/shift_pipe.sv
// shift_pipe: two-stage registered rotate / logical-shift unit with valid/ready on both sides.
// Define SHIFT_PIPE_ZERO_EN to add a registered out_zero flag (result == 0).
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module shift_pipe #(
    parameter int n = `DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [n-1:0]         in_a,
    input  logic [$clog2(n)-1:0] in_b,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [n-1:0]         out_data
`ifdef SHIFT_PIPE_ZERO_EN
    ,
    output logic                 out_zero
`endif
);
    localparam int bw = $clog2(n);
    localparam logic [1:0] op_rol = 2'b00;
    localparam logic [1:0] op_ror = 2'b01;
    localparam logic [1:0] op_shl = 2'b10;

    logic           s1_valid;
    logic [n-1:0]   a;
    logic [bw-1:0]  b;
    logic [1:0]     op;
    logic           s1_advance;
    logic [2*n-1:0] rol_wide;
    logic [2*n-1:0] ror_wide;
    logic [n-1:0]   ones;
    logic [n-1:0]   result;

    // Handshake: a word moves across a port on every rising edge where valid && ready
    // are both high; valid never depends on ready, and once S2 holds a result it stays
    // until out_ready takes it. in_ready is high during reset; anything offered then is dropped.
    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = reset || !s1_valid || s1_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            a        <= '0;
            b        <= '0;
            op       <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                a  <= in_a;
                b  <= in_b;
                op <= in_op;
            end
        end
    end

    // Rotates come from a doubled operand; logical shifts mask the wrapped-in bits.
    always_comb begin
        rol_wide = {a, a} << b;
        ror_wide = {a, a} >> b;
        ones     = '1;
        result   = '0;
        case (op)
            op_rol:  result = rol_wide[2*n-1:n];
            op_ror:  result = ror_wide[n-1:0];
            op_shl:  result = rol_wide[2*n-1:n] & (ones << b);
            default: result = ror_wide[n-1:0] & (ones >> b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= result;
            end
        end
    end

`ifdef SHIFT_PIPE_ZERO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_zero <= 1'b1;
        end else if (s1_advance && s1_valid) begin
            out_zero <= (result == '0);
        end
    end
`else
    // Without the flag the output register carries no zero-detect state.
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (n=8): directed vector table, stall, reset and
// random-handshake streams, with a scoreboard fed by an independent shift model.
`timescale 1ns/1ps

module tb_shift_pipe;
    localparam int W  = 8;
    localparam int BW = $clog2(W);
    localparam int NV = 14;
    localparam int NRAND = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [BW-1:0] in_b;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef SHIFT_PIPE_ZERO_EN
    logic          out_zero;
`endif

    typedef struct {
        logic [W-1:0]  a;
        logic [BW-1:0] b;
        logic [1:0]    op;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t         tbl[NV];
    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_out = 0;

    shift_pipe #(.n(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFT_PIPE_ZERO_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [BW-1:0] b,
                                           input logic [1:0] op);
        logic [W-1:0] r;
        int           s;
        s = int'(b);
        case (op)
            2'b00:   r = W'((a << s) | (a >> (W - s)));
            2'b01:   r = W'((a >> s) | (a << (W - s)));
            2'b10:   r = W'(a << s);
            default: r = W'(a >> s);
        endcase
        return r;
    endfunction

    // ---------------- checkers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_spurious: got %h, required no output (t=%0t)", out_data, $time);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e);
`ifdef SHIFT_PIPE_ZERO_EN
                    check1("sb_zero", out_zero, e == '0);
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_op));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input vec_t t);
        in_valid = v;
        in_a     = t.a;
        in_b     = t.b;
        in_op    = t.op;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   idx;
        int   sent;
        int   out0;
        logic have;
        logic [W-1:0] hold;
        vec_t cur;

        tbl[0]  = '{8'h87, 3'd3, 2'b00, 8'h3C};
        tbl[1]  = '{8'h87, 3'd3, 2'b01, 8'hF0};
        tbl[2]  = '{8'h87, 3'd3, 2'b10, 8'h38};
        tbl[3]  = '{8'h87, 3'd3, 2'b11, 8'h10};
        tbl[4]  = '{8'hA5, 3'd0, 2'b00, 8'hA5};
        tbl[5]  = '{8'hA5, 3'd0, 2'b01, 8'hA5};
        tbl[6]  = '{8'hA5, 3'd0, 2'b10, 8'hA5};
        tbl[7]  = '{8'hA5, 3'd0, 2'b11, 8'hA5};
        tbl[8]  = '{8'h0F, 3'd7, 2'b11, 8'h00};
        tbl[9]  = '{8'hFF, 3'd7, 2'b10, 8'h80};
        tbl[10] = '{8'hFF, 3'd7, 2'b11, 8'h01};
        tbl[11] = '{8'h01, 3'd7, 2'b00, 8'h80};
        tbl[12] = '{8'h01, 3'd1, 2'b01, 8'h80};
        tbl[13] = '{8'hB4, 3'd4, 2'b00, 8'h4B};

        // reset state
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check1("rst_in_ready_during", in_ready, 1'b1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check1("rst_in_ready", in_ready, 1'b1);
        next_cycle();

        // back-to-back table with exact latency and no bubbles
        for (int c = 0; c < NV + 2; c++) begin
            if (c < NV) drive(1'b1, tbl[c]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (c < NV) check1("b2b_in_ready", in_ready, 1'b1);
            if (c < 2) begin
                check1("b2b_latency_idle", out_valid, 1'b0);
            end else begin
                check1("b2b_out_valid", out_valid, 1'b1);
                check("b2b_out_data", out_data, tbl[c-2].exp);
`ifdef SHIFT_PIPE_ZERO_EN
                check1("b2b_out_zero", out_zero, tbl[c-2].exp == '0);
`endif
            end
            next_cycle();
        end
        @(negedge clk);
        check1("b2b_drained", out_valid, 1'b0);
        next_cycle();

        // stall: 10 ops, out_ready low for cycles 3..6
        idx = 0; out0 = n_out; hold = '0;
        for (int cyc = 0; cyc < 60 && !(idx == 10 && exp_q.size() == 0); cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 7);
            if (idx < 10) drive(1'b1, tbl[idx]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (cyc >= 3 && cyc < 7) begin
                check1("stall_out_valid", out_valid, 1'b1);
                check1("stall_in_ready", in_ready, 1'b0);
                if (cyc == 3) hold = out_data;
                else check("stall_hold", out_data, hold);
            end
            if (in_valid && in_ready) idx++;
            next_cycle();
        end
        check("stall_count", W'(n_out - out0), 8'd10);
        check1("stall_q_empty", exp_q.size() == 0, 1'b1);

        // reset with both stages full: nothing from before reset may appear
        out_ready = 1'b0;
        drive(1'b1, tbl[0]);
        next_cycle();
        drive(1'b1, tbl[13]);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check1("full_before_reset", out_valid, 1'b1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check1("midrst_in_ready_during", in_ready, 1'b1);
        next_cycle();
        reset = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check1("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 8'h00);
        check1("midrst_in_ready", in_ready, 1'b1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check1("midrst_no_stale", out_valid, 1'b0);
            next_cycle();
        end

        // random handshakes on both sides
        sent = 0; out0 = n_out; have = 1'b0;
        cur = '{8'h00, 3'd0, 2'b00, 8'h00};
        for (int cyc = 0; cyc < 20000 && !(sent == NRAND && exp_q.size() == 0); cyc++) begin
            if (!have && sent < NRAND) begin
                cur.a  = 8'($urandom_range(0, 255));
                cur.b  = 3'($urandom_range(0, 7));
                cur.op = 2'($urandom_range(0, 3));
                have   = 1'b1;
            end
            drive(have && ($urandom_range(0, 1) == 1), cur);
            out_ready = (sent < NRAND) ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                have = 1'b0;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        check1("rand_done", sent == NRAND && exp_q.size() == 0, 1'b1);
        check1("rand_count", (n_out - out0) == NRAND, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
